// File: rtl/imap_biu.sv
// Input-map bus interface: fetches cfg_len words from cfg_base_addr over a credit-limited read port
// and streams them downstream through a FWFT FIFO. Define IMAP_BIU_ADDR_CHK_EN to add response-address checking.
module imap_biu #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_start,
  input  logic [31:0] cfg_base_addr,
  input  logic [15:0] cfg_len,
  output logic        busy,
  output logic        done,
  output logic        addr_err,
  output logic [31:0] imap_biu2arb_addr,
  output logic        imap_biu2arb_vld,
  input  logic        imap_biu2arb_rdy,
  input  logic [31:0] arb2imap_biu_addr,
  input  logic [31:0] arb2imap_biu_data,
  input  logic        arb2imap_biu_vld,
  output logic        arb2imap_biu_rdy,
  output logic [31:0] imap_data,
  output logic        imap_vld,
  input  logic        imap_rdy
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int AW1 = AW + 1;
  localparam int AW2 = AW + 2;
  localparam logic [AW:0]   DEPTH_C = AW1'(FIFO_DEPTH);
  localparam logic [AW+1:0] DEPTH_W = AW2'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic          req_vld_q, req_vld_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   req_cnt_q, req_cnt_d;
  logic [15:0]   dlv_cnt_q, dlv_cnt_d;
  logic [AW:0]   outst_q, outst_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          zero_done_q, zero_done_d;
  logic [31:0]   mem_q [FIFO_DEPTH];

  logic          req_hs, push, pop, fifo_empty, fifo_full, fin, accept;
  logic [AW+1:0] credit_nxt;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == DEPTH_C);
  assign req_hs     = req_vld_q && imap_biu2arb_rdy;
  assign push       = arb2imap_biu_vld && !fifo_full;
  assign pop        = !fifo_empty && imap_rdy;
  assign fin        = (state_q == DRAIN) && (dlv_cnt_q == len_q);
  assign accept     = cfg_start && !busy;

  assign busy              = (state_q == REQ) || ((state_q == DRAIN) && !fin);
  assign done              = zero_done_q || fin;
  assign imap_biu2arb_addr = req_addr_q;
  assign imap_biu2arb_vld  = req_vld_q;
  assign arb2imap_biu_rdy  = !fifo_full;
  assign imap_vld          = !fifo_empty;
  assign imap_data         = fifo_empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    zero_done_d = 1'b0;
    req_cnt_d   = req_cnt_q + 16'(req_hs);
    dlv_cnt_d   = dlv_cnt_q + 16'(pop);
    req_addr_d  = req_hs ? req_addr_q + 32'd4 : req_addr_q;
    outst_d     = outst_q + AW1'(req_hs) - AW1'(push);
    cnt_d       = cnt_q + AW1'(push) - AW1'(pop);
    wr_ptr_d    = wr_ptr_q + AW'(push);
    rd_ptr_d    = rd_ptr_q + AW'(pop);

    case (state_q)
      REQ:     if (req_hs && (req_cnt_d == len_q)) state_d = DRAIN;
      DRAIN:   if (fin) state_d = IDLE;
      default: ;
    endcase

    if (accept) begin
      if (cfg_len == 16'd0) begin
        zero_done_d = 1'b1;
        state_d     = IDLE;
      end else begin
        state_d    = REQ;
        len_d      = cfg_len;
        req_cnt_d  = '0;
        dlv_cnt_d  = '0;
        outst_d    = '0;
        req_addr_d = cfg_base_addr;
      end
    end

    // Requests in flight plus buffered words may never exceed the FIFO, so the response side never stalls on overflow.
    credit_nxt = AW2'(outst_q) + AW2'(cnt_q) + AW2'(req_hs) - AW2'(pop);
    req_vld_d  = (req_vld_q && !imap_biu2arb_rdy) ||
                 ((state_q == REQ) && (req_cnt_d < len_q) && (credit_nxt < DEPTH_W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      req_vld_q   <= 1'b0;
      len_q       <= '0;
      req_cnt_q   <= '0;
      dlv_cnt_q   <= '0;
      outst_q     <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_vld_q   <= req_vld_d;
      len_q       <= len_d;
      req_cnt_q   <= req_cnt_d;
      dlv_cnt_q   <= dlv_cnt_d;
      outst_q     <= outst_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      zero_done_q <= zero_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= arb2imap_biu_data;
  end

`ifdef IMAP_BIU_ADDR_CHK_EN
  logic [31:0] exp_addr_q, exp_addr_d;
  logic        addr_err_q, addr_err_d;

  always_comb begin
    exp_addr_d = push ? exp_addr_q + 32'd4 : exp_addr_q;
    addr_err_d = addr_err_q;
    if (push && (arb2imap_biu_addr != exp_addr_q)) addr_err_d = 1'b1;
    if (accept) begin
      exp_addr_d = cfg_base_addr;
      addr_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_addr_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      exp_addr_q <= exp_addr_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign addr_err = addr_err_q;
`else
  logic unused_rsp_addr;
  assign unused_rsp_addr = ^arb2imap_biu_addr;
  assign addr_err        = 1'b0;
`endif

endmodule

// File: tb/tb_imap_biu.sv
// Directed bench for imap_biu: arbiter/downstream models plus a transfer-level reference model
// checked every cycle, and literal expectations for the headline scenarios.
module tb_imap_biu;
  localparam int DEPTH = 8;
`ifdef IMAP_BIU_ADDR_CHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic [31:0] cfg_base_addr;
  logic [15:0] cfg_len;
  logic        busy, done, addr_err;
  logic [31:0] imap_biu2arb_addr;
  logic        imap_biu2arb_vld;
  logic        imap_biu2arb_rdy = 1'b1;
  logic [31:0] arb2imap_biu_addr = '0;
  logic [31:0] arb2imap_biu_data = '0;
  logic        arb2imap_biu_vld = 1'b0;
  logic        arb2imap_biu_rdy;
  logic [31:0] imap_data;
  logic        imap_vld;
  logic        imap_rdy = 1'b1;

  imap_biu #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr), .cfg_len(cfg_len),
    .busy(busy), .done(done), .addr_err(addr_err),
    .imap_biu2arb_addr(imap_biu2arb_addr), .imap_biu2arb_vld(imap_biu2arb_vld),
    .imap_biu2arb_rdy(imap_biu2arb_rdy),
    .arb2imap_biu_addr(arb2imap_biu_addr), .arb2imap_biu_data(arb2imap_biu_data),
    .arb2imap_biu_vld(arb2imap_biu_vld), .arb2imap_biu_rdy(arb2imap_biu_rdy),
    .imap_data(imap_data), .imap_vld(imap_vld), .imap_rdy(imap_rdy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (transfer-level view)
  logic        m_active = 1'b0, m_zero = 1'b0, m_err = 1'b0, m_err_n;
  logic [31:0] m_base = '0;
  logic [15:0] m_len = '0;
  int          m_iss = 0, m_rsp = 0, m_dlv = 0;
  logic        exp_busy, exp_done;
  int          done_cnt = 0;
  logic [31:0] arb_q[$];
  logic [31:0] req_log[$];
  logic [31:0] data_log[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  int   cyc = 0;
  logic arb_mode = 1'b0, dn_mode = 1'b0, dn_hold = 1'b0, corrupt = 1'b0;

  function automatic logic [31:0] data_fn(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Arbiter and downstream behaviour, driven just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    imap_biu2arb_rdy = arb_mode ? ((cyc % 3) != 0) : 1'b1;
    imap_rdy = dn_hold ? 1'b0 : (dn_mode ? ((cyc % 4) < 2) : 1'b1);
    if (arb_q.size() > 0 && (!arb_mode || (cyc % 5) != 1)) begin
      arb2imap_biu_vld  = 1'b1;
      arb2imap_biu_addr = (corrupt && arb_q[0] == 32'h0000_1004) ? 32'h0000_1008 : arb_q[0];
      arb2imap_biu_data = data_fn(arb_q[0]);
    end else begin
      arb2imap_biu_vld  = 1'b0;
      arb2imap_biu_addr = '0;
      arb2imap_biu_data = '0;
    end
  end

  // Compare process: mid-cycle sampling against the reference model.
  always @(negedge clk) begin
    if (rst) begin
      m_active = 1'b0; m_zero = 1'b0; m_err = 1'b0;
      m_iss = 0; m_rsp = 0; m_dlv = 0;
      arb_q.delete();
      prev_stall = 1'b0;
    end else begin
      exp_busy = m_active && (m_dlv != int'(m_len));
      exp_done = m_zero || (m_active && (m_dlv == int'(m_len)));
      m_err_n  = m_err;
      check1("busy", busy, exp_busy);
      check1("done", done, exp_done);
      check1("addr_err", addr_err, m_err);
      if (done) done_cnt++;
      if (prev_stall) begin
        check1("req_hold_vld", imap_biu2arb_vld, 1'b1);
        check32("req_hold_addr", imap_biu2arb_addr, prev_addr);
      end
      prev_stall = imap_biu2arb_vld && !imap_biu2arb_rdy;
      prev_addr  = imap_biu2arb_addr;
      if (imap_biu2arb_vld)
        check1("req_legal", m_active && (m_iss < int'(m_len)) && ((m_iss - m_dlv) < DEPTH), 1'b1);
      if (imap_biu2arb_vld && imap_biu2arb_rdy) begin
        check32("req_addr", imap_biu2arb_addr, m_base + 32'(m_iss) * 32'd4);
        m_iss++;
        arb_q.push_back(imap_biu2arb_addr);
        req_log.push_back(imap_biu2arb_addr);
      end
      if (arb2imap_biu_vld && arb2imap_biu_rdy) begin
`ifdef IMAP_BIU_ADDR_CHK_EN
        if (arb2imap_biu_addr != m_base + 32'(m_rsp) * 32'd4) m_err_n = 1'b1;
`endif
        m_rsp++;
        void'(arb_q.pop_front());
      end
      if (imap_vld && imap_rdy) begin
        check32("data", imap_data, data_fn(m_base + 32'(m_dlv) * 32'd4));
        m_dlv++;
        data_log.push_back(imap_data);
      end
      if (exp_done) m_active = 1'b0;
      m_zero = 1'b0;
      if (cfg_start && !exp_busy) begin
        m_err_n = 1'b0;
        if (cfg_len == 16'd0) m_zero = 1'b1;
        else begin
          m_active = 1'b1; m_base = cfg_base_addr; m_len = cfg_len;
          m_iss = 0; m_rsp = 0; m_dlv = 0;
        end
      end
      m_err = m_err_n;
    end
  end

  task automatic start(input logic [31:0] b, input logic [15:0] l);
    cfg_base_addr = b; cfg_len = l; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string name);
    int d0 = done_cnt;
    int i = 0;
    while (done_cnt == d0 && i < bound) begin
      @(posedge clk); i++;
    end
    #1;
    check32(name, 32'(done_cnt - d0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check32({name, "_once"}, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_busy"}, busy, 1'b0);
    check1({tag, "_done"}, done, 1'b0);
    check1({tag, "_addr_err"}, addr_err, 1'b0);
    check1({tag, "_req_vld"}, imap_biu2arb_vld, 1'b0);
    check32({tag, "_req_addr"}, imap_biu2arb_addr, 32'h0);
    check1({tag, "_rsp_rdy"}, arb2imap_biu_rdy, 1'b1);
    check1({tag, "_imap_vld"}, imap_vld, 1'b0);
    check32({tag, "_imap_data"}, imap_data, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, sd, d0;
    logic [31:0] ea [4];
    rst = 1'b1; cfg_start = 1'b0; cfg_base_addr = '0; cfg_len = '0;
    repeat (2) @(posedge clk); #1;
    check_reset_outputs("rst0");
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic fetch, latency of two cycles to first request
    s = req_log.size(); sd = data_log.size();
    start(32'h0000_1000, 16'd4);
    check1("lat_vld_c1", imap_biu2arb_vld, 1'b0);
    check1("lat_busy_c1", busy, 1'b1);
    @(posedge clk); #1;
    check1("lat_vld_c2", imap_biu2arb_vld, 1'b1);
    check32("lat_addr_c2", imap_biu2arb_addr, 32'h0000_1000);
    wait_done(200, "basic_done");
    check1("basic_busy_after", busy, 1'b0);
    check32("basic_nreq", 32'(req_log.size() - s), 32'd4);
    ea = '{32'h0000_1000, 32'h0000_1004, 32'h0000_1008, 32'h0000_100C};
    for (int k = 0; k < 4; k++) check32("basic_addr", req_log[s + k], ea[k]);
    ea = '{32'h5A5A_1000, 32'h5A5A_1004, 32'h5A5A_1008, 32'h5A5A_100C};
    for (int k = 0; k < 4; k++) check32("basic_data", data_log[sd + k], ea[k]);

    // Address wrap at 2^32
    s = req_log.size(); sd = data_log.size();
    start(32'hFFFF_FFF8, 16'd4);
    wait_done(200, "wrap_done");
    ea = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    for (int k = 0; k < 4; k++) check32("wrap_addr", req_log[s + k], ea[k]);
    check32("wrap_data2", data_log[sd + 2], 32'h5A5A_0000);

    // Zero-length start
    s = req_log.size(); d0 = done_cnt;
    start(32'h0000_7000, 16'd0);
    check1("zero_done", done, 1'b1);
    check1("zero_busy", busy, 1'b0);
    @(posedge clk); #1;
    check1("zero_done_end", done, 1'b0);
    repeat (3) @(posedge clk); #1;
    check32("zero_nreq", 32'(req_log.size() - s), 32'd0);
    check32("zero_ndone", 32'(done_cnt - d0), 32'd1);

    // Start while busy is ignored
    s = req_log.size(); sd = data_log.size();
    start(32'h0000_3000, 16'd6);
    repeat (2) @(posedge clk); #1;
    start(32'h0000_5000, 16'd3);
    wait_done(300, "ign_done");
    check32("ign_nreq", 32'(req_log.size() - s), 32'd6);
    check32("ign_last_addr", req_log[req_log.size() - 1], 32'h0000_3014);
    check32("ign_ndata", 32'(data_log.size() - sd), 32'd6);

    // Downstream back-pressure limits outstanding to the FIFO depth
    dn_hold = 1'b1;
    s = req_log.size(); sd = data_log.size();
    start(32'h0000_4000, 16'd20);
    repeat (40) @(posedge clk); #1;
    check32("bp_nreq", 32'(req_log.size() - s), 32'd8);
    check1("bp_req_vld", imap_biu2arb_vld, 1'b0);
    check1("bp_rsp_rdy", arb2imap_biu_rdy, 1'b0);
    check1("bp_imap_vld", imap_vld, 1'b1);
    check32("bp_head", imap_data, 32'h5A5A_4000);
    dn_hold = 1'b0;
    wait_done(400, "bp_done");
    check32("bp_ndata", 32'(data_log.size() - sd), 32'd20);
    check32("bp_last", data_log[data_log.size() - 1], 32'h5A5A_404C);

    // Stalling arbiter and downstream
    arb_mode = 1'b1; dn_mode = 1'b1;
    sd = data_log.size();
    start(32'h0000_8000, 16'd12);
    wait_done(800, "stall_done");
    check32("stall_ndata", 32'(data_log.size() - sd), 32'd12);
    check32("stall_last", data_log[data_log.size() - 1], 32'h5A5A_802C);
    arb_mode = 1'b0; dn_mode = 1'b0;

    // Reset in the middle of a transfer
    start(32'h0000_6000, 16'd10);
    for (int i = 0; i < 100 && m_dlv < 3; i++) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    sd = data_log.size();
    start(32'h0000_2000, 16'd2);
    wait_done(200, "post_rst_done");
    check32("post_rst_ndata", 32'(data_log.size() - sd), 32'd2);
    check32("post_rst_d0", data_log[sd], 32'h5A5A_2000);
    check32("post_rst_d1", data_log[sd + 1], 32'h5A5A_2004);

    // Response address mismatch
    corrupt = 1'b1;
    sd = data_log.size();
    start(32'h0000_1000, 16'd4);
    wait_done(200, "err_done");
    check1("err_flag", addr_err, ERR_EXP);
    check32("err_data1", data_log[sd + 1], 32'h5A5A_1004);
    corrupt = 1'b0;
    repeat (2) @(posedge clk); #1;
    check1("err_sticky", addr_err, ERR_EXP);
    start(32'h0000_9000, 16'd1);
    check1("err_clear", addr_err, 1'b0);
    wait_done(200, "clr_done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/imap_biu.md
IMAP_BIU -- requirements
Module: imap_biu

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, response buffer depth in 32-bit words (power of two, 2..64); also the cap on outstanding reads.
REQ-002 SHALL have ports, one clock domain:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- cfg_start  in  1  one-cycle start pulse
- cfg_base_addr  in  32  first word address, byte-addressed, word-aligned
- cfg_len  in  16  words to fetch
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- addr_err  out  1  sticky response-address mismatch flag
- imap_biu2arb_addr  out  32  read request address
- imap_biu2arb_vld  out  1  read request valid
- imap_biu2arb_rdy  in  1  read request accepted
- arb2imap_biu_addr  in  32  response address
- arb2imap_biu_data  in  32  response data
- arb2imap_biu_vld  in  1  response valid
- arb2imap_biu_rdy  out  1  response ready
- imap_data  out  32  word to downstream compute
- imap_vld  out  1  downstream valid
- imap_rdy  in  1  downstream ready

Function
REQ-003 SHALL implement FSM IDLE -> REQ -> DRAIN -> IDLE.
REQ-004 SHALL, in IDLE, on cfg_start with cfg_len!=0, latch base/len, clear counters, enter REQ next cycle; busy=1 from that cycle.
REQ-005 SHALL, on cfg_start with cfg_len==0, stay IDLE and pulse done one cycle later, issuing no requests.
REQ-006 SHALL ignore cfg_start while busy=1.
REQ-007 SHALL assert imap_biu2arb_vld in REQ only while outstanding + fifo_count < FIFO_DEPTH; addr/vld held stable until rdy.
REQ-008 SHALL count a request as issued on vld&&rdy; address advances by 4, wrapping modulo 2^32.
REQ-009 SHALL enter DRAIN the cycle after the cfg_len-th request handshake.
REQ-010 SHALL drive arb2imap_biu_rdy = !fifo_full; responses arrive in request order.
REQ-011 SHALL write data into FIFO on arb2imap_biu_vld&&rdy and decrement outstanding; simultaneous request handshake and response leaves outstanding unchanged.
REQ-012 SHALL present FIFO head on imap_data with imap_vld=!fifo_empty, first-word-fall-through; pop on imap_vld&&imap_rdy; simultaneous push/pop at any count leaves count unchanged.
REQ-013 SHALL, in DRAIN, when delivered count reaches cfg_len, pulse done for one cycle, deassert busy in that same cycle, and return to IDLE.
REQ-014 SHALL give minimum latency of 2 cycles from cfg_start to first imap_biu2arb_vld.
REQ-015 SHALL never overflow FIFO under any arbiter/downstream stall pattern, guaranteed by the REQ-007 credit rule.

Reset
REQ-016 SHALL, on rst high, asynchronously force IDLE, clear counters/FIFO pointers, and drive busy=0, done=0, addr_err=0, imap_biu2arb_vld=0, imap_biu2arb_addr=0, arb2imap_biu_rdy=1 (FIFO empty), imap_vld=0, imap_data=0.
REQ-017 SHALL, on reset mid-transfer, abandon all in-flight state; late arbiter responses after deassertion are the system's responsibility.

Configuration
REQ-018 SHALL support macro IMAP_BIU_ADDR_CHK_EN: when defined, compare arb2imap_biu_addr against expected in-order address on each accepted response, set addr_err sticky on mismatch, clear only by reset or next accepted cfg_start; data still buffered.
REQ-019 SHALL, without IMAP_BIU_ADDR_CHK_EN, tie addr_err to 0 and leave no comparison logic.

Verification
REQ-020 Fetch base=0x1000, len=4, arbiter/downstream always ready -> requests 0x1000,0x1004,0x1008,0x100C; imap_data in same order; one done pulse; busy low after.
REQ-021 len=20, FIFO_DEPTH=8, imap_rdy held 0 -> exactly 8 requests issued, then vld low; release imap_rdy -> all 20 words delivered, no loss.
REQ-022 base=0xFFFFFFF8, len=4 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
REQ-023 cfg_start with len=0 -> no requests, done pulse next cycle; cfg_start mid-transfer -> ignored, original transfer completes.
REQ-024 rst asserted after 3 of 10 words delivered -> all outputs at reset values immediately; new start base=0x2000, len=2 completes normally.
REQ-025 With IMAP_BIU_ADDR_CHK_EN, return 0x1008 in place of 0x1004 -> addr_err=1 from next cycle, sticky; without macro addr_err stays 0.
